// File: rtl/isp_stats_pkg.sv
// Shared definitions for the image statistics blocks: FSM encoding,
// default geometry constants and a small width helper.
package isp_stats_pkg;

  localparam int DEF_NUM_CH    = 3;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_SHIFT = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mean_stats_if.sv
// Pixel stream in, per-channel mean results out, for the mean_stats block.
interface mean_stats_if #(
  parameter int NUM_CH    = isp_stats_pkg::DEF_NUM_CH,
  parameter int DATA_W    = isp_stats_pkg::DEF_DATA_W,
  parameter int MAX_SHIFT = isp_stats_pkg::DEF_MAX_SHIFT
);
  localparam int CH_W    = isp_stats_pkg::clog2_min1(NUM_CH);
  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);

  logic                     valid_i;
  logic [CH_W-1:0]          color_i;
  logic [DATA_W-1:0]        value_i;
  logic                     sof_i;
  logic                     last_i;
  logic [SHIFT_W-1:0]       shift_i;
  logic                     round_en_i;
  logic [NUM_CH*DATA_W-1:0] mean_o;
  logic                     valid_o;
  logic                     busy_o;
  logic [NUM_CH-1:0]        ovf_o;
  logic                     drop_o;

  modport master (
    output valid_i, color_i, value_i, sof_i, last_i, shift_i, round_en_i,
    input  mean_o, valid_o, busy_o, ovf_o, drop_o
  );

  modport slave (
    input  valid_i, color_i, value_i, sof_i, last_i, shift_i, round_en_i,
    output mean_o, valid_o, busy_o, ovf_o, drop_o
  );
endinterface

// File: rtl/mean_stats_div.sv
// Combinational mean of one channel: optional round-half-up, right shift,
// then saturation to the output pixel width.
module mean_div
  import isp_stats_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_DATA_W + DEF_MAX_SHIFT,
  parameter int SHIFT_W = $clog2(DEF_MAX_SHIFT + 1)
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               round_en,
  output logic [DATA_W-1:0]  mean
);
  logic [ACC_W:0] half;
  logic [ACC_W:0] sum;
  logic [ACC_W:0] quot;

  // (1 << shift) >> 1 is 2^(shift-1) for shift > 0 and 0 for shift == 0.
  assign half = round_en ? (({{ACC_W{1'b0}}, 1'b1} << shift) >> 1) : '0;
  assign sum  = {1'b0, acc} + half;
  assign quot = sum >> shift;
  assign mean = (|quot[ACC_W:DATA_W]) ? '1 : quot[DATA_W-1:0];
endmodule

// File: rtl/mean_stats.sv
// Per-channel frame mean: accumulates pixel values per colour channel, then
// runs one shared divider over the channels and publishes all means together.
module mean_stats
  import isp_stats_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
  input  logic       clk,
  input  logic       rst_n,
  mean_stats_if.slave bus
);
  localparam int ACC_W   = DATA_W + MAX_SHIFT;
  localparam int CH_W    = clog2_min1(NUM_CH);
  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(MAX_SHIFT);
  localparam logic [CH_W-1:0]    LAST_CH   = CH_W'(NUM_CH - 1);

  logic                 s1_valid_reg;
  logic [CH_W-1:0]      s1_color_reg;
  logic [DATA_W-1:0]    s1_value_reg;
  logic                 s1_sof_reg;
  logic                 s1_last_reg;
  logic [SHIFT_W-1:0]   s1_shift_reg;
  logic                 s1_round_reg;

  state_t               state_reg, state_next;
  logic [CH_W-1:0]      ch_idx_reg, ch_idx_next;
  logic [SHIFT_W-1:0]   shift_reg;
  logic                 round_reg;
  logic                 valid_reg;
  logic                 drop_reg;

  logic                 color_ok;
  logic                 sof_take;
  logic                 pix_take;
  logic                 drop_set;
  logic                 div_we;
  logic                 div_done;

  logic [ACC_W-1:0]          acc_arr [NUM_CH];
  logic [ACC_W-1:0]          div_acc;
  logic [DATA_W-1:0]         div_mean;
  logic [NUM_CH*DATA_W-1:0]  mean_flat;
  logic [NUM_CH-1:0]         ovf_flat;

  assign color_ok = ({1'b0, s1_color_reg} < (CH_W + 1)'(NUM_CH));

  always_comb begin
    state_next  = state_reg;
    ch_idx_next = ch_idx_reg;
    sof_take    = 1'b0;
    pix_take    = 1'b0;
    drop_set    = 1'b0;
    div_we      = 1'b0;
    div_done    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        sof_take = s1_sof_reg;
        pix_take = s1_valid_reg && s1_sof_reg && color_ok;
        drop_set = s1_valid_reg && !(s1_sof_reg && color_ok);
        if (s1_sof_reg) begin
          state_next = (s1_valid_reg && s1_last_reg) ? ST_DIV : ST_ACC;
        end
      end
      ST_ACC: begin
        sof_take = s1_sof_reg;
        pix_take = s1_valid_reg && color_ok;
        drop_set = s1_valid_reg && !color_ok;
        if (s1_valid_reg && s1_last_reg) begin
          state_next = ST_DIV;
        end
      end
      ST_DIV: begin
        // Accumulators are being read out, so nothing may start a frame here.
        drop_set = s1_valid_reg || s1_sof_reg;
        div_we   = 1'b1;
        if (ch_idx_reg == LAST_CH) begin
          div_done    = 1'b1;
          ch_idx_next = '0;
          state_next  = ST_IDLE;
        end else begin
          ch_idx_next = ch_idx_reg + CH_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_color_reg <= '0;
      s1_value_reg <= '0;
      s1_sof_reg   <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_shift_reg <= '0;
      s1_round_reg <= 1'b0;
      state_reg    <= ST_IDLE;
      ch_idx_reg   <= '0;
      shift_reg    <= '0;
      round_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      s1_valid_reg <= bus.valid_i;
      s1_color_reg <= bus.color_i;
      s1_value_reg <= bus.value_i;
      s1_sof_reg   <= bus.sof_i;
      s1_last_reg  <= bus.last_i;
      s1_shift_reg <= bus.shift_i;
      s1_round_reg <= bus.round_en_i;
      state_reg    <= state_next;
      ch_idx_reg   <= ch_idx_next;
      if (sof_take) begin
        shift_reg <= (s1_shift_reg > SHIFT_MAX) ? SHIFT_MAX : s1_shift_reg;
        round_reg <= s1_round_reg;
      end
      valid_reg <= div_done;
      drop_reg  <= drop_reg | drop_set;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [ACC_W-1:0]  acc_reg;
    logic              ovf_reg;
    logic [DATA_W-1:0] mean_reg;
    logic              hit;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W:0]    acc_sum;

    assign hit      = pix_take && (s1_color_reg == CH_W'(gi));
    // A same-cycle sof clears first, so the pixel lands on a zeroed accumulator.
    assign acc_base = sof_take ? '0 : acc_reg;
    assign acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - DATA_W){1'b0}}, s1_value_reg};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_reg  <= '0;
        ovf_reg  <= 1'b0;
        mean_reg <= '0;
      end else begin
        if (sof_take || hit) begin
          acc_reg <= !hit ? '0 : (acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0]);
          ovf_reg <= (!sof_take && ovf_reg) || (hit && acc_sum[ACC_W]);
        end
        if (div_we && (ch_idx_reg == CH_W'(gi))) begin
          mean_reg <= div_mean;
        end
      end
    end

    assign acc_arr[gi]                      = acc_reg;
    assign mean_flat[gi*DATA_W +: DATA_W]   = mean_reg;
    assign ovf_flat[gi]                     = ovf_reg;
  end

  assign div_acc = acc_arr[ch_idx_reg];

  mean_div #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SHIFT_W (SHIFT_W)
  ) u_div (
    .acc      (div_acc),
    .shift    (shift_reg),
    .round_en (round_reg),
    .mean     (div_mean)
  );

  assign bus.mean_o  = mean_flat;
  assign bus.valid_o = valid_reg;
  assign bus.busy_o  = (state_reg == ST_DIV);
  assign bus.ovf_o   = ovf_flat;
  assign bus.drop_o  = drop_reg;
endmodule
